// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the dual-issue front end.
// Contents:
//   - major opcode constants (instr[6:0])
//   - NOP_INSTR: canonical addi x0,x0,0
//   - instr_entry_t: one queue slot {instr, pc}
//   - op_class_t / classify(): per-opcode register and pipeline properties
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } instr_entry_t;

  typedef struct packed {
    logic writes_rd;
    logic reads_rs1;
    logic reads_rs2;
    logic is_ctrl;   // redirects fetch: must be the last instruction of a pair
    logic is_load;
    logic is_store;
  } op_class_t;

  function automatic op_class_t classify(input logic [6:0] opcode);
    op_class_t c;
    c = '0;
    // Unknown opcodes are treated as rs1 readers so the dependence check stays conservative.
    c.reads_rs1 = 1'b1;
    case (opcode)
      OP:     begin c.writes_rd = 1'b1; c.reads_rs2 = 1'b1; end
      OP_IMM: c.writes_rd = 1'b1;
      LOAD:   begin c.writes_rd = 1'b1; c.is_load = 1'b1; end
      STORE:  begin c.reads_rs2 = 1'b1; c.is_store = 1'b1; end
      BRANCH: begin c.reads_rs2 = 1'b1; c.is_ctrl = 1'b1; end
      JALR:   begin c.writes_rd = 1'b1; c.is_ctrl = 1'b1; end
      JAL:    begin c.writes_rd = 1'b1; c.is_ctrl = 1'b1; c.reads_rs1 = 1'b0; end
      LUI,
      AUIPC:  begin c.writes_rd = 1'b1; c.reads_rs1 = 1'b0; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pair_check.sv
// Combinational pairing check for the two oldest queued instructions.
// Ports:
//   instr1  in  32  older instruction (decode pipeline 1)
//   instr2  in  32  younger instruction (decode pipeline 2)
//   hazard  out 1   instr2 must not issue in the same cycle as instr1
module pair_check
  import riscv_pkg::*;
(
  input  logic [31:0] instr1,
  input  logic [31:0] instr2,
  output logic        hazard
);

  op_class_t  c1, c2;
  logic [4:0] rd1;
  logic       raw;

  // funct3/funct7 never influence pairing.
  logic unused_fields;
  assign unused_fields = ^{instr1[31:12], instr2[31:25], instr2[14:0]};

  assign c1  = classify(instr1[6:0]);
  assign c2  = classify(instr2[6:0]);
  assign rd1 = instr1[11:7];

  // x0 is hard-wired, so writing it creates no dependence.
  assign raw = c1.writes_rd && (rd1 != 5'd0) &&
               ((c2.reads_rs1 && (instr2[19:15] == rd1)) ||
                (c2.reads_rs2 && (instr2[24:20] == rd1)));

  // Pipeline 1 owns stores, pipeline 2 owns loads; two memory ops never pair.
  assign hazard = raw
               || c1.is_ctrl
               || ((c1.is_load || c1.is_store) && (c2.is_load || c2.is_store))
               || c2.is_store
               || c1.is_load;

endmodule

// File: rtl/dual_issue_queue.sv
// Circular instruction buffer between fetch and dual-pipeline decode.
// Accepts up to two fetched instructions per cycle, presents the oldest one
// or two (show-ahead) and issues the second only when pair_check allows it.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid[1:0]              fetch slot valids (bit0 older; bit1 needs bit0)
//   in_instr0/1, in_pc0/1      fetched instructions and PCs, older first
//   in_ready                   at least two free entries
//   stall_d                    decode stalled: hold the pair, dequeue nothing
//   flush                      redirect: empty the queue (beats stall_d, enqueue)
//   InstrD1/2, PCD1/2          presented pair (NOP / 0 when the slot is invalid)
//   ValidD1/2                  slot valids
//   count                      occupancy
module dual_issue_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 8,   // power of two, >= 4
  parameter int XLEN  = 32   // must equal riscv_pkg::XLEN (entry layout)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               in_valid,
  input  logic [31:0]              in_instr0,
  input  logic [31:0]              in_instr1,
  input  logic [XLEN-1:0]          in_pc0,
  input  logic [XLEN-1:0]          in_pc1,
  output logic                     in_ready,
  input  logic                     stall_d,
  input  logic                     flush,
  output logic [31:0]              InstrD1,
  output logic [31:0]              InstrD2,
  output logic [XLEN-1:0]          PCD1,
  output logic [XLEN-1:0]          PCD2,
  output logic                     ValidD1,
  output logic                     ValidD2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  instr_entry_t    mem [DEPTH];
  logic [PW-1:0]   hd, tl, hd_p1, tl_p1;
  logic [1:0]      enq, deq;
  instr_entry_t    head1, head2;
  logic            hazard;

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  assign hd_p1 = hd + PW'(1);
  assign tl_p1 = tl + PW'(1);
  assign head1 = mem[hd];
  assign head2 = mem[hd_p1];

  pair_check u_pair_check (
    .instr1 (head1.instr),
    .instr2 (head2.instr),
    .hazard (hazard)
  );

  // in_ready looks at the current count only, so a full-rate enqueue can
  // never overrun the array even when nothing drains in the same cycle.
  assign in_ready = (CW'(DEPTH) - count) >= CW'(2);

  // NOTE: every output of this block gets a value on every path (defaults
  // first), so no latch is inferred.
  always_comb begin
    ValidD1 = 1'b0;
    ValidD2 = 1'b0;
    InstrD1 = NOP_INSTR;
    InstrD2 = NOP_INSTR;
    PCD1    = '0;
    PCD2    = '0;
    enq     = 2'd0;
    deq     = 2'd0;

    ValidD1 = (count != '0);
    ValidD2 = (count >= CW'(2)) && !hazard;
    if (ValidD1) begin
      InstrD1 = head1.instr;
      PCD1    = head1.pc;
    end
    if (ValidD2) begin
      InstrD2 = head2.instr;
      PCD2    = head2.pc;
    end

    if (in_ready && in_valid[0]) enq = in_valid[1] ? 2'd2 : 2'd1;
    if (!stall_d)                deq = {1'b0, ValidD1} + {1'b0, ValidD2};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else if (flush) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else begin
      hd    <= hd + PW'(deq);
      tl    <= tl + PW'(enq);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // NOTE: the entry array has no reset; its contents are only observed once
  // count says they were written, which keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (enq != 2'd0) mem[tl]    <= '{instr: in_instr0, pc: in_pc0};
      if (enq == 2'd2) mem[tl_p1] <= '{instr: in_instr1, pc: in_pc1};
    end
  end

endmodule

// File: tb/tb_dual_issue_queue.sv
// Self-checking bench for dual_issue_queue: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_dual_issue_queue;

  localparam int DEPTH = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] T_OP = 7'h33, T_OPI = 7'h13, T_LD = 7'h03, T_ST = 7'h23,
                         T_BR = 7'h63, T_JAL = 7'h6f, T_JALR = 7'h67,
                         T_LUI = 7'h37, T_AUIPC = 7'h17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_valid;
  logic [31:0] in_instr0, in_instr1, in_pc0, in_pc1;
  logic        in_ready, stall_d, flush;
  logic [31:0] InstrD1, InstrD2, PCD1, PCD2;
  logic        ValidD1, ValidD2;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  // Reference model: program-ordered list of pending instructions.
  logic [31:0] mq_instr[$];
  logic [31:0] mq_pc[$];
  logic        exp_v1, exp_v2, exp_rdy;
  logic [31:0] exp_i1, exp_i2, exp_p1, exp_p2;
  logic [3:0]  exp_cnt;
  logic [31:0] pc_next = 32'h1000;

  dual_issue_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_instr0(in_instr0), .in_instr1(in_instr1),
    .in_pc0(in_pc0), .in_pc1(in_pc1), .in_ready(in_ready),
    .stall_d(stall_d), .flush(flush),
    .InstrD1(InstrD1), .InstrD2(InstrD2), .PCD1(PCD1), .PCD2(PCD2),
    .ValidD1(ValidD1), .ValidD2(ValidD2), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Pairing rules written straight from the instruction semantics.
  function automatic bit ref_hazard(input logic [31:0] s1, input logic [31:0] s2);
    logic [6:0] o1 = s1[6:0];
    logic [6:0] o2 = s2[6:0];
    logic [4:0] rd = s1[11:7];
    bit wr   = o1 inside {T_OP, T_OPI, T_LD, T_LUI, T_AUIPC, T_JAL, T_JALR};
    bit use1 = !(o2 inside {T_LUI, T_AUIPC, T_JAL});
    bit use2 = o2 inside {T_OP, T_ST, T_BR};
    bit dep  = wr && rd != 0 && ((use1 && s2[19:15] == rd) || (use2 && s2[24:20] == rd));
    bit ctl  = o1 inside {T_BR, T_JAL, T_JALR};
    bit mem2 = (o1 inside {T_LD, T_ST}) && (o2 inside {T_LD, T_ST});
    return dep || ctl || mem2 || o2 == T_ST || o1 == T_LD;
  endfunction

  function automatic logic [31:0] mk_addi(input int rd, input int imm);
    return {12'(imm), 5'd0, 3'b000, 5'(rd), T_OPI};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9] = '{T_OP, T_OPI, T_LD, T_ST, T_BR, T_JAL, T_JALR, T_LUI, T_AUIPC};
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]};
  endfunction

  task automatic model_outputs();
    exp_cnt = 4'(mq_instr.size());
    exp_v1  = mq_instr.size() >= 1;
    exp_v2  = (mq_instr.size() >= 2) ? !ref_hazard(mq_instr[0], mq_instr[1]) : 1'b0;
    exp_i1  = exp_v1 ? mq_instr[0] : NOP;
    exp_p1  = exp_v1 ? mq_pc[0]    : 32'h0;
    exp_i2  = exp_v2 ? mq_instr[1] : NOP;
    exp_p2  = exp_v2 ? mq_pc[1]    : 32'h0;
    exp_rdy = (DEPTH - mq_instr.size()) >= 2;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
    in_valid  = v;
    in_instr0 = i0;
    in_instr1 = i1;
    in_pc0    = pc_next;
    in_pc1    = pc_next + 32'd4;
    pc_next   = pc_next + 32'd8;
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // leave time 1ns after the edge for sampling.
  task automatic tick();
    int ndeq;
    @(posedge clk);
    if (!rst_n || flush) begin
      mq_instr.delete();
      mq_pc.delete();
    end else begin
      ndeq = stall_d ? 0 : int'(exp_v1) + int'(exp_v2);
      repeat (ndeq) begin
        void'(mq_instr.pop_front());
        void'(mq_pc.pop_front());
      end
      if (exp_rdy && in_valid[0]) begin
        mq_instr.push_back(in_instr0); mq_pc.push_back(in_pc0);
        if (in_valid[1]) begin
          mq_instr.push_back(in_instr1); mq_pc.push_back(in_pc1);
        end
      end
    end
    #1;
    model_outputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_d = 1'b0; flush = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    #3;
    checks++; if ({ValidD1, ValidD2} !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", {ValidD1, ValidD2}); end
    checks++; if (InstrD1 !== NOP || InstrD2 !== NOP) begin errors++; $display("FAIL reset_instr got=%h/%h exp=%h", InstrD1, InstrD2, NOP); end
    checks++; if (PCD1 !== 32'h0 || PCD2 !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h/%h exp=0", PCD1, PCD2); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_pair();
    drive(2'b11, 32'h0050_0093, 32'h0070_0193);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    checks++; if ({ValidD1, ValidD2} !== 2'b11) begin errors++; $display("FAIL pair_valid got=%b exp=11", {ValidD1, ValidD2}); end
    checks++; if (InstrD1 !== 32'h0050_0093 || InstrD2 !== 32'h0070_0193) begin errors++; $display("FAIL pair_instr got=%h/%h exp=00500093/00700193", InstrD1, InstrD2); end
    checks++; if (PCD1 !== exp_p1 || PCD2 !== exp_p2) begin errors++; $display("FAIL pair_pc got=%h/%h exp=%h/%h", PCD1, PCD2, exp_p1, exp_p2); end
    tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL pair_drain got=%0d exp=0", count); end
  endtask

  task automatic test_raw();
    drive(2'b11, 32'h0050_0093, 32'h0010_8133);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    checks++; if ({ValidD1, ValidD2} !== 2'b10 || InstrD2 !== NOP || PCD2 !== 32'h0) begin errors++; $display("FAIL raw_split got v=%b i2=%h pc2=%h exp v=10 i2=%h pc2=0", {ValidD1, ValidD2}, InstrD2, PCD2, NOP); end
    tick();
    checks++; if (InstrD1 !== 32'h0010_8133 || ValidD1 !== 1'b1) begin errors++; $display("FAIL raw_second got=%h v=%b exp=00108133 v=1", InstrD1, ValidD1); end
    tick();
  endtask

  task automatic test_branch();
    drive(2'b11, 32'h0000_0463, 32'h0070_0193);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    checks++; if (InstrD1 !== 32'h0000_0463 || ValidD2 !== 1'b0) begin errors++; $display("FAIL branch_alone got=%h v2=%b exp=00000463 v2=0", InstrD1, ValidD2); end
    tick();
    checks++; if (InstrD1 !== 32'h0070_0193 || ValidD1 !== 1'b1) begin errors++; $display("FAIL branch_next got=%h v1=%b exp=00700193 v1=1", InstrD1, ValidD1); end
    tick();
  endtask

  task automatic test_load_store();
    drive(2'b11, 32'h0000_2283, 32'h0050_2223);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    checks++; if (InstrD1 !== 32'h0000_2283 || ValidD2 !== 1'b0) begin errors++; $display("FAIL lw_alone got=%h v2=%b exp=00002283 v2=0", InstrD1, ValidD2); end
    tick();
    checks++; if (InstrD1 !== 32'h0050_2223 || ValidD1 !== 1'b1) begin errors++; $display("FAIL sw_next got=%h v1=%b exp=00502223 v1=1", InstrD1, ValidD1); end
    tick();
    drive(2'b11, 32'h0050_0093, 32'h0000_2303);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    checks++; if (ValidD2 !== 1'b1 || InstrD2 !== 32'h0000_2303) begin errors++; $display("FAIL lw_paired got v2=%b i2=%h exp v2=1 i2=00002303", ValidD2, InstrD2); end
    tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL lw_drain got=%0d exp=0", count); end
  endtask

  // Fills under stall until in_ready drops, then drains across the wrap point.
  task automatic test_stall_wrap();
    logic [31:0] first;
    first   = mk_addi(4, 1);
    stall_d = 1'b1;
    drive(2'b01, first, 32'h0);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, mk_addi(5 + 2 * k, k + 10), mk_addi(6 + 2 * k, k + 20));
      tick();
      checks++;
      if ({ValidD1, ValidD2, InstrD1, InstrD2, PCD1, PCD2, count, in_ready} !==
          {exp_v1, exp_v2, exp_i1, exp_i2, exp_p1, exp_p2, exp_cnt, exp_rdy}) begin
        errors++;
        $display("FAIL stall_fill k=%0d got v=%b%b i=%h/%h pc=%h/%h cnt=%0d rdy=%b exp v=%b%b i=%h/%h pc=%h/%h cnt=%0d rdy=%b",
                 k, ValidD1, ValidD2, InstrD1, InstrD2, PCD1, PCD2, count, in_ready,
                 exp_v1, exp_v2, exp_i1, exp_i2, exp_p1, exp_p2, exp_cnt, exp_rdy);
      end
      checks++; if (InstrD1 !== first) begin errors++; $display("FAIL stall_hold k=%0d got=%h exp=%h", k, InstrD1, first); end
    end
    checks++; if (count !== 4'd7 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_full got cnt=%0d rdy=%b exp cnt=7 rdy=0", count, in_ready); end
    stall_d = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({ValidD1, ValidD2, InstrD1, InstrD2, PCD1, PCD2, count, in_ready} !==
          {exp_v1, exp_v2, exp_i1, exp_i2, exp_p1, exp_p2, exp_cnt, exp_rdy}) begin
        errors++;
        $display("FAIL stall_drain k=%0d got v=%b%b i=%h/%h pc=%h/%h cnt=%0d exp v=%b%b i=%h/%h pc=%h/%h cnt=%0d",
                 k, ValidD1, ValidD2, InstrD1, InstrD2, PCD1, PCD2, count,
                 exp_v1, exp_v2, exp_i1, exp_i2, exp_p1, exp_p2, exp_cnt);
      end
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL stall_empty got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    stall_d = 1'b1;
    drive(2'b01, mk_addi(1, 1), 32'h0);
    tick();
    drive(2'b11, mk_addi(2, 2), mk_addi(3, 3));
    tick();
    drive(2'b11, mk_addi(4, 4), mk_addi(5, 5));
    tick();
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_setup got=%0d exp=5", count); end
    flush = 1'b1;
    drive(2'b11, mk_addi(6, 6), mk_addi(7, 7));
    tick();
    flush = 1'b0; stall_d = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    checks++; if (count !== 4'd0 || ValidD1 !== 1'b0 || InstrD1 !== NOP || PCD1 !== 32'h0) begin errors++; $display("FAIL flush_empty got cnt=%0d v1=%b i1=%h pc1=%h exp cnt=0 v1=0 i1=%h pc1=0", count, ValidD1, InstrD1, PCD1, NOP); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom_range(0, 3)), rand_instr(), rand_instr());
      stall_d = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 31) == 0);
      tick();
      checks++;
      if ({ValidD1, ValidD2, InstrD1, InstrD2, PCD1, PCD2, count, in_ready} !==
          {exp_v1, exp_v2, exp_i1, exp_i2, exp_p1, exp_p2, exp_cnt, exp_rdy}) begin
        errors++;
        $display("FAIL random n=%0d got v=%b%b i=%h/%h pc=%h/%h cnt=%0d rdy=%b exp v=%b%b i=%h/%h pc=%h/%h cnt=%0d rdy=%b",
                 n, ValidD1, ValidD2, InstrD1, InstrD2, PCD1, PCD2, count, in_ready,
                 exp_v1, exp_v2, exp_i1, exp_i2, exp_p1, exp_p2, exp_cnt, exp_rdy);
      end
      checks++; if (count > 4'(DEPTH)) begin errors++; $display("FAIL random_bound n=%0d got cnt=%0d exp <=%0d", n, count, DEPTH); end
    end
    stall_d = 1'b0; flush = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    repeat (DEPTH) tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL random_drain got=%0d exp=0", count); end
  endtask

  task automatic test_reset_mid();
    stall_d = 1'b1;
    drive(2'b11, mk_addi(8, 8), mk_addi(9, 9));
    tick();
    drive(2'b00, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({ValidD1, ValidD2} !== 2'b00 || count !== 4'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL midreset_state got v=%b%b cnt=%0d rdy=%b exp v=00 cnt=0 rdy=1", ValidD1, ValidD2, count, in_ready); end
    checks++; if (InstrD1 !== NOP || InstrD2 !== NOP || PCD1 !== 32'h0 || PCD2 !== 32'h0) begin errors++; $display("FAIL midreset_out got i=%h/%h pc=%h/%h exp i=%h pc=0", InstrD1, InstrD2, PCD1, PCD2, NOP); end
    tick();
    rst_n   = 1'b1;
    stall_d = 1'b0;
    drive(2'b11, 32'h0050_0093, 32'h0070_0193);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    checks++; if ({ValidD1, ValidD2, InstrD1, InstrD2, count} !== {exp_v1, exp_v2, exp_i1, exp_i2, exp_cnt}) begin errors++; $display("FAIL midreset_resume got v=%b%b i=%h/%h cnt=%0d exp v=%b%b i=%h/%h cnt=%0d", ValidD1, ValidD2, InstrD1, InstrD2, count, exp_v1, exp_v2, exp_i1, exp_i2, exp_cnt); end
    tick();
  endtask

  initial begin
    test_reset();
    test_pair();
    test_raw();
    test_branch();
    test_load_store();
    test_stall_wrap();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dual_issue_queue.md
Name: dual_issue_queue

Overview:
- Instruction buffer and pairing stage between fetch and the dual-pipeline decode stage.
- Accepts up to two fetched instructions per cycle and stores them in program order in a circular queue.
- Each cycle it presents the oldest one or two instructions as the slot-1/slot-2 decode pair.
- It issues slot 2 only when that instruction can legally execute alongside slot 1.

Parameters:
- DEPTH, 8, queue entries; power of two, minimum 4.
- XLEN, 32, instruction and PC width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  2  per-slot valid for fetched instructions; bit0 is the older instruction; bit1 is ignored unless bit0=1.
- in_instr0, in_instr1  in  32 each  fetched instructions, older first.
- in_pc0, in_pc1  in  32 each  PCs of the fetched instructions.
- in_ready  out  1  high when free entries >= 2.
- stall_d  in  1  decode stalled; hold the presented pair and dequeue nothing.
- flush  in  1  redirect; empty the queue.
- InstrD1, InstrD2  out  32 each  instructions presented to decode pipelines 1 and 2.
- PCD1, PCD2  out  32 each  PCs of the presented instructions.
- ValidD1, ValidD2  out  1 each  slot valid.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry array of {instr, pc}. Head pointer hd, tail pointer tl, each $clog2(DEPTH) bits, wrapping modulo DEPTH. Occupancy count.
- Reset (async, rst_n=0): hd=0, tl=0, count=0, ValidD1=ValidD2=0, InstrD1=InstrD2=NOP (0x00000013), PCD1=PCD2=0, in_ready=1. Array contents are don't-care.
- Outputs are combinational from the head entries (show-ahead); an instruction written at edge N is presentable after edge N.
- Invalid slots drive InstrD=NOP and PCD=0, so decode generates no writes or stores.
- ValidD1 = (count>=1).
- ValidD2 = (count>=2) && !hazard(entry[hd], entry[hd+1]).
- hazard is true when any of the following hold:
  - (a) Slot 1 writes a register (opcode OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR), its rd != 0, and slot 2 reads that rd. Slot 2 reads rs1 for all opcodes except LUI/AUIPC/JAL; it reads rs2 for OP, STORE, BRANCH.
  - (b) Slot 1 is BRANCH, JAL or JALR.
  - (c) Both slots are LOAD/STORE.
  - (d) Slot 2 is a STORE, or slot 1 is a LOAD. Pipeline 1 owns stores and pipeline 2 owns loads.
- When hazard holds, slot 2 drives NOP and issues on a later cycle.
- Dequeue at the edge: deq = stall_d ? 0 : ValidD1 + ValidD2; hd += deq.
- Enqueue at the edge: enq = in_ready ? (in_valid[0] + (in_valid[0]&in_valid[1])) : 0. Writes go to tl and tl+1 in order; tl += enq.
- count_next = count + enq - deq. Enqueue and dequeue in the same cycle are legal. in_ready is computed from the current count, not count_next.
- in_valid while in_ready=0: the input is dropped. Fetch must hold its instructions.
- flush=1: at the edge, hd=tl=0 and count=0. Same-cycle enqueue is discarded, and flush overrides stall_d. Outputs become invalid/NOP the cycle after.
- Wrap-around: when tl=DEPTH-1 with enq=2, the second write goes to entry 0. The pair read at hd=DEPTH-1 uses entry 0 as slot 2.
- No overflow is possible by construction. Bench asserts count <= DEPTH and that the queue never dequeues more than count.

Decomposition:
- riscv_pkg holds:
  - opcode constants: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - NOP_INSTR = 32'h00000013.
  - an instr_entry_t struct {instr, pc}.
- Sub-module pair_check: purely combinational. Inputs are the two instructions; output is hazard. Unit-tested separately.

Test Plan:
- Reset, then enqueue 0x00500093 (addi x1,x0,5) and 0x00700193 (addi x3,x0,7) in one cycle -> next cycle ValidD1=ValidD2=1 with those instructions; following cycle count=0.
- Enqueue 0x00500093 then 0x00108133 (add x2,x1,x1) -> cycle 1: ValidD1=1, ValidD2=0, InstrD2=0x00000013. Cycle 2: InstrD1=0x00108133.
- Enqueue 0x00000463 (beq) then 0x00700193 -> branch issues alone; the addi issues the next cycle in slot 1.
- Enqueue 0x00002283 (lw x5) then 0x00502223 (sw x5) -> issued singly on consecutive cycles. Repeat with an independent lw in slot 2 behind an addi -> paired.
- Hold stall_d=1 while enqueuing pairs until in_ready=0 at count=7 (DEPTH=8) -> outputs stable, inputs dropped. Release stall_d -> drains in order, pointers wrap, no loss.
- With count=5, assert flush together with in_valid=2'b11 -> next cycle count=0, ValidD1=0. Also pulse rst_n low mid-operation -> all outputs take reset values immediately.
